// File: rtl/gf180mcu_osu_sc_gp12t3v3__addf_seq.sv
// Bit-serial adder sequencer driving one external full-adder cell, LSB first.
// Latency WIDTH+1 edges START->DONE; START ignored while BUSY, accepted in IDLE/DONE.
module gf180mcu_osu_sc_gp12t3v3__addf_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_CI,
  input  logic             FA_S,
  input  logic             FA_CO,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state <= ST_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // SUM is left alone on accept; the next run shifts the old result out.
          if (START) begin
            sh_a  <= A;
            sh_b  <= B;
            carry <= CIN;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_q <= {FA_S, sum_q[WIDTH-1:1]};
          carry <= FA_CO;
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          if (cnt == LAST) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The final carry stays in the carry register until the next accepted START.
  assign FA_A  = sh_a[0];
  assign FA_B  = sh_b[0];
  assign FA_CI = carry;
  assign BUSY  = (state == ST_RUN);
  assign DONE  = (state == ST_DONE);
  assign SUM   = sum_q;
  assign COUT  = carry;

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__addf_seq.md
# gf180mcu_osu_sc_gp12t3v3__addf_seq

Bit-serial add sequencer that time-shares one external full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It captures operands on a start request and drives the cell's A/B/CI inputs from internal shift and carry registers. It samples the cell's S/CO outputs each cycle and reports the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting controller and a single combinational full-adder instance, trading latency for area.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CLK  input  1  clock; all state updates on the rising edge.
- R  input  1  reset; asynchronous, active-high.
- START  input  1  request; sampled only in IDLE or DONE state.
- A  input  WIDTH  operand A; captured when START is accepted.
- B  input  WIDTH  operand B; captured when START is accepted.
- CIN  input  1  carry-in; captured when START is accepted.
- FA_A  output  1  to full-adder A; equals the current A shift-register bit 0.
- FA_B  output  1  to full-adder B; equals the current B shift-register bit 0.
- FA_CI  output  1  to full-adder CI; equals the carry register.
- FA_S  input  1  from full-adder S; combinational function of FA_A/FA_B/FA_CI.
- FA_CO  input  1  from full-adder CO; combinational function of FA_A/FA_B/FA_CI.
- BUSY  output  1  high in RUN state.
- DONE  output  1  one-cycle pulse in DONE state.
- SUM  output  WIDTH  result; held stable from DONE until the next accepted START.
- COUT  output  1  final carry; held with SUM.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE.** On START=1:
  - load shA←A, shB←B, carry←CIN, cnt←0;
  - go to RUN.
- **RUN.** Each edge:
  - shift FA_S into SUM at bit WIDTH-1, with SUM shifting right;
  - carry←FA_CO;
  - shA and shB shift right, with 0 filled in;
  - cnt←cnt+1.
  - When cnt=WIDTH-1 at the edge, go to DONE.
  - START is ignored in RUN.
- **DONE.** This state lasts exactly one cycle. COUT equals the carry register.
  - START=1: reload the operands as in IDLE, go to RUN, and clear SUM progressively as it shifts.
  - START=0: go to IDLE.
- SUM/COUT are valid only from DONE until the next accepted START. During RUN, SUM holds partial shifted data.
- In IDLE and DONE, FA_A and FA_B are 0 because the shift registers are drained. FA_CI equals the carry register.
- cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
- **Reset values.** BUSY=0, DONE=0, SUM=0, COUT=0, FA_A=0, FA_B=0, FA_CI=0, all internal registers 0.
- **Reset mid-RUN.** The operation is aborted immediately. No DONE pulse is produced, and outputs take their reset values.

## Timing
- An accepted START at edge 0 gives: BUSY high after edge 0; bits 0..WIDTH-1 computed at edges 1..WIDTH; DONE high after edge WIDTH for one cycle.
- Latency from START to DONE is WIDTH+1 edges. BUSY stays high for WIDTH cycles.
- Back-to-back START in DONE gives one operation per WIDTH+1 cycles with no idle gap.
- The FA path is combinational within one cycle: register → FA cell → FA_S/FA_CO → register. There is no output register on the cell.
- Operand inputs are don't-care except at the accepting edge.

## Test plan
- **Basic add.** WIDTH=8, A=0x5A, B=0x3C, CIN=0, START pulsed → DONE 9 edges later, SUM=0x96, COUT=0, BUSY high for exactly 8 cycles.
- **Carry ripple.** A=0xFF, B=0x01, CIN=0 → SUM=0x00, COUT=1. A=0xFF, B=0xFF, CIN=1 → SUM=0xFF, COUT=1.
- **START ignored in RUN.** Assert START at the 3rd RUN cycle with different operands → first result is unchanged (0x5A+0x3C=0x96) and no second operation starts.
- **Back-to-back.** START held high continuously with A=0x01, B=0x02, then A=0x80, B=0x80 → DONE pulses 9 cycles apart; results 0x03/COUT=0, then 0x00/COUT=1.
- **Async reset mid-RUN.** Assert R between edges during RUN cycle 4 → BUSY, DONE, SUM, COUT and FA_* all 0 immediately. After release, IDLE is held until START; the next add gives the correct result.
- **Exhaustive.** WIDTH=2, all 32 combinations of A, B and CIN → {COUT,SUM}=A+B+CIN every time, compared against a behavioural full-adder model on the FA_* ports.
